denoise_edge_top: RTL and testbench

- Binary-image post-processor for 128x128 images held in four external 8-bit, 16384-word RAMs (RAM0..RAM3). Addresses are row-major: addr = row*128 + col.
- Four sequential engines, each with its own RAM port and RAM-select output:
  - forward and backward: a two-pass chessboard distance transform, done in place in RAM0.
  - threshold: writes a denoised mask to RAM3.
  - convolution: writes a 4-neighbour edge map to RAM2.
- Asserts done when all four finish. RAM1 is never accessed.

---
 rtl/denoise_edge_top.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_denoise_edge_top.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/denoise_edge_top.sv
// denoise_edge_top: in-place two-pass chessboard distance transform on RAM0,
// threshold denoise into RAM3, then 4-neighbour edge extraction into RAM2.
// One shared sequencer walks the image per phase; each engine sees the
// sequencer's registered strobes only while its own phase is active.
module denoise_edge_top #(
  parameter int THRESH = 1,
  parameter int IMG_W  = 128,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] forward_di,
  input  logic [DATA_W-1:0] backward_di,
  input  logic [DATA_W-1:0] threshold_di,
  input  logic [DATA_W-1:0] convolution_di,
  output logic [13:0]       forward_addr,
  output logic [13:0]       backward_addr,
  output logic [13:0]       threshold_addr,
  output logic [13:0]       convolution_addr,
  output logic              forward_wr,
  output logic              backward_wr,
  output logic              threshold_wr,
  output logic              convolution_wr,
  output logic              forward_rd,
  output logic              backward_rd,
  output logic              threshold_rd,
  output logic              convolution_rd,
  output logic [DATA_W-1:0] forward_do,
  output logic [DATA_W-1:0] backward_do,
  output logic              threshold_do,
  output logic              convolution_do,
  output logic [2:0]        f_RAM_sel,
  output logic [2:0]        b_RAM_sel,
  output logic [2:0]        t_RAM_sel,
  output logic [2:0]        c_RAM_sel,
  output logic              done
);

  localparam int LOG_W = $clog2(IMG_W);
  localparam logic [LOG_W-1:0] LAST   = LOG_W'(IMG_W - 1);
  localparam logic [LOG_W:0]   OFF_M1 = '1;
  localparam logic [LOG_W:0]   OFF_P1 = (LOG_W+1)'(1);
  localparam logic [LOG_W:0]   OFF_Z  = '0;
  localparam logic [2:0]       SEL_OFF = 3'd7;

  typedef enum logic [2:0] {P_IDLE, P_FWD, P_BWD, P_THR, P_CONV, P_DONE} phase_t;

  function automatic logic [DATA_W-1:0] min_u(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] a);
    return (a == {DATA_W{1'b1}}) ? a : a + 1'b1;
  endfunction

  phase_t            phase, phase_n;
  logic [2:0]        step, step_n;
  logic [LOG_W-1:0]  row, row_n, col, col_n;
  logic              rd_q, rd_n, wr_q, wr_n;
  logic [13:0]       addr_q, addr_n;
  logic [DATA_W-1:0] do_q, do_n;
  logic [2:0]        sel_q, sel_n;
  logic [DATA_W-1:0] cen, cen_n, acc, acc_n;
  logic              zseen, zseen_n;

  logic [DATA_W-1:0] di_mux, cur, nb_min, res;
  logic [2:0]        rd_sel, wr_sel;
  logic [1:0]        k;
  logic [LOG_W:0]    dr, dc, nr, nc;
  logic              nb_ok;
  logic [13:0]       cen_addr, nb_addr;

  // Route the active engine's read data and pick its read/write RAM index.
  always_comb begin
    di_mux = '0;
    rd_sel = SEL_OFF;
    wr_sel = SEL_OFF;
    case (phase)
      P_FWD:  begin di_mux = forward_di;     rd_sel = 3'd0; wr_sel = 3'd0; end
      P_BWD:  begin di_mux = backward_di;    rd_sel = 3'd0; wr_sel = 3'd0; end
      P_THR:  begin di_mux = threshold_di;   rd_sel = 3'd0; wr_sel = 3'd3; end
      P_CONV: begin di_mux = convolution_di; rd_sel = 3'd3; wr_sel = 3'd2; end
      default: ;
    endcase
  end

  // Neighbour k of the current pixel; out-of-image shows up as a carry into bit LOG_W.
  always_comb begin
    k  = step[1:0] - 2'd1;
    dr = OFF_Z;
    dc = OFF_Z;
    case (phase)
      P_FWD:
        case (k)
          2'd0:    begin dr = OFF_M1; dc = OFF_M1; end
          2'd1:    dr = OFF_M1;
          2'd2:    begin dr = OFF_M1; dc = OFF_P1; end
          default: dc = OFF_M1;
        endcase
      P_BWD:
        case (k)
          2'd0:    dc = OFF_P1;
          2'd1:    begin dr = OFF_P1; dc = OFF_M1; end
          2'd2:    dr = OFF_P1;
          default: begin dr = OFF_P1; dc = OFF_P1; end
        endcase
      P_CONV:
        case (k)
          2'd0:    dr = OFF_M1;
          2'd1:    dr = OFF_P1;
          2'd2:    dc = OFF_P1;
          default: dc = OFF_M1;
        endcase
      default: ;
    endcase
    nr       = {1'b0, row} + dr;
    nc       = {1'b0, col} + dc;
    nb_ok    = ~nr[LOG_W] & ~nc[LOG_W];
    nb_addr  = 14'({nr[LOG_W-1:0], nc[LOG_W-1:0]});
    cen_addr = 14'({row, col});
  end

  // Per-phase result from the centre and the running neighbour minimum / zero flag.
  always_comb begin
    cur    = rd_q ? di_mux : '0;
    nb_min = min_u(acc, cur);
    case (phase)
      P_FWD:   res = sat_inc(nb_min);
      P_BWD:   res = min_u(cen, sat_inc(nb_min));
      default: res = {{(DATA_W-1){1'b0}}, (cen != '0) && (zseen || (cur == '0))};
    endcase
  end

  // Sequencer next state: step 0 reads centre, 1..4 issue neighbours while
  // collecting the previous read, 5 writes, 6 advances pixel or phase.
  always_comb begin
    phase_n = phase;
    step_n  = step;
    row_n   = row;
    col_n   = col;
    rd_n    = 1'b0;
    wr_n    = 1'b0;
    addr_n  = addr_q;
    do_n    = do_q;
    sel_n   = sel_q;
    cen_n   = cen;
    acc_n   = acc;
    zseen_n = zseen;
    case (phase)
      P_IDLE: begin
        phase_n = P_FWD;
        step_n  = '0;
        row_n   = '0;
        col_n   = '0;
      end
      P_FWD, P_BWD, P_THR, P_CONV: begin
        case (step)
          3'd0: begin
            rd_n    = 1'b1;
            addr_n  = cen_addr;
            sel_n   = rd_sel;
            acc_n   = '1;
            zseen_n = 1'b0;
            step_n  = 3'd1;
          end
          3'd1: begin
            cen_n = cur;
            if ((phase == P_FWD || phase == P_BWD) && cur == '0) begin
              step_n = 3'd6;
            end else if (phase == P_THR) begin
              wr_n   = 1'b1;
              addr_n = cen_addr;
              do_n   = {{(DATA_W-1){1'b0}}, cur > DATA_W'(THRESH)};
              sel_n  = wr_sel;
              step_n = 3'd6;
            end else begin
              rd_n   = nb_ok;
              addr_n = nb_ok ? nb_addr : addr_q;
              sel_n  = rd_sel;
              step_n = 3'd2;
            end
          end
          3'd2, 3'd3, 3'd4: begin
            acc_n   = nb_min;
            zseen_n = zseen | (cur == '0);
            rd_n    = nb_ok;
            addr_n  = nb_ok ? nb_addr : addr_q;
            sel_n   = rd_sel;
            step_n  = step + 3'd1;
          end
          3'd5: begin
            wr_n   = 1'b1;
            addr_n = cen_addr;
            do_n   = res;
            sel_n  = wr_sel;
            step_n = 3'd6;
          end
          default: begin
            step_n = '0;
            if (phase == P_BWD) begin
              if (col != '0) begin
                col_n = col - 1'b1;
              end else if (row != '0) begin
                row_n = row - 1'b1;
                col_n = LAST;
              end else begin
                phase_n = P_THR;
                row_n   = '0;
                col_n   = '0;
              end
            end else begin
              if (col != LAST) begin
                col_n = col + 1'b1;
              end else if (row != LAST) begin
                row_n = row + 1'b1;
                col_n = '0;
              end else begin
                row_n = '0;
                col_n = '0;
                case (phase)
                  P_FWD:   begin phase_n = P_BWD; row_n = LAST; col_n = LAST; end
                  P_THR:   phase_n = P_CONV;
                  default: phase_n = P_DONE;
                endcase
              end
            end
          end
        endcase
      end
      default: ;
    endcase
  end

  // Control and port registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase  <= P_IDLE;
      step   <= '0;
      row    <= '0;
      col    <= '0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      do_q   <= '0;
      sel_q  <= SEL_OFF;
    end else begin
      phase  <= phase_n;
      step   <= step_n;
      row    <= row_n;
      col    <= col_n;
      rd_q   <= rd_n;
      wr_q   <= wr_n;
      addr_q <= addr_n;
      do_q   <= do_n;
      sel_q  <= sel_n;
    end
  end

  // Per-pixel working data; always rewritten before use so it needs no reset.
  always_ff @(posedge clk) begin
    cen   <= cen_n;
    acc   <= acc_n;
    zseen <= zseen_n;
  end

  assign forward_rd       = (phase == P_FWD)  && rd_q;
  assign backward_rd      = (phase == P_BWD)  && rd_q;
  assign threshold_rd     = (phase == P_THR)  && rd_q;
  assign convolution_rd   = (phase == P_CONV) && rd_q;
  assign forward_wr       = (phase == P_FWD)  && wr_q;
  assign backward_wr      = (phase == P_BWD)  && wr_q;
  assign threshold_wr     = (phase == P_THR)  && wr_q;
  assign convolution_wr   = (phase == P_CONV) && wr_q;
  assign forward_addr     = (phase == P_FWD)  ? addr_q : '0;
  assign backward_addr    = (phase == P_BWD)  ? addr_q : '0;
  assign threshold_addr   = (phase == P_THR)  ? addr_q : '0;
  assign convolution_addr = (phase == P_CONV) ? addr_q : '0;
  assign forward_do       = (phase == P_FWD)  ? do_q : '0;
  assign backward_do      = (phase == P_BWD)  ? do_q : '0;
  assign threshold_do     = (phase == P_THR)  && do_q[0];
  assign convolution_do   = (phase == P_CONV) && do_q[0];
  assign f_RAM_sel        = (phase == P_FWD)  ? sel_q : SEL_OFF;
  assign b_RAM_sel        = (phase == P_BWD)  ? sel_q : SEL_OFF;
  assign t_RAM_sel        = (phase == P_THR)  ? sel_q : SEL_OFF;
  assign c_RAM_sel        = (phase == P_CONV) ? sel_q : SEL_OFF;
  assign done             = (phase == P_DONE);

endmodule

// File: tb/tb_denoise_edge_top.sv
// tb_denoise_edge_top: drives the post-processor on a 16x16 image with a
// behavioural RAM model and compares RAM contents against an array model.
module tb_denoise_edge_top;

  localparam int W      = 16;
  localparam int NPIX   = W * W;
  localparam int THR    = 1;
  localparam int BUDGET = 48 * NPIX + 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  di_a [4];
  logic [13:0] f_addr, b_addr, t_addr, c_addr;
  logic        f_wr, b_wr, t_wr, c_wr, f_rd, b_rd, t_rd, c_rd;
  logic [7:0]  f_do, b_do;
  logic        t_do, c_do;
  logic [2:0]  f_sel, b_sel, t_sel, c_sel;
  logic        done;

  denoise_edge_top #(.THRESH(THR), .IMG_W(W), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .forward_di(di_a[0]), .backward_di(di_a[1]),
    .threshold_di(di_a[2]), .convolution_di(di_a[3]),
    .forward_addr(f_addr), .backward_addr(b_addr),
    .threshold_addr(t_addr), .convolution_addr(c_addr),
    .forward_wr(f_wr), .backward_wr(b_wr), .threshold_wr(t_wr), .convolution_wr(c_wr),
    .forward_rd(f_rd), .backward_rd(b_rd), .threshold_rd(t_rd), .convolution_rd(c_rd),
    .forward_do(f_do), .backward_do(b_do), .threshold_do(t_do), .convolution_do(c_do),
    .f_RAM_sel(f_sel), .b_RAM_sel(b_sel), .t_RAM_sel(t_sel), .c_RAM_sel(c_sel),
    .done(done)
  );

  logic [13:0] addr_a [4];
  logic        rd_a [4];
  logic        wr_a [4];
  logic [7:0]  do_a [4];
  logic [2:0]  sel_a [4];

  always_comb begin
    addr_a[0] = f_addr; addr_a[1] = b_addr; addr_a[2] = t_addr; addr_a[3] = c_addr;
    rd_a[0] = f_rd; rd_a[1] = b_rd; rd_a[2] = t_rd; rd_a[3] = c_rd;
    wr_a[0] = f_wr; wr_a[1] = b_wr; wr_a[2] = t_wr; wr_a[3] = c_wr;
    do_a[0] = f_do; do_a[1] = b_do; do_a[2] = {7'd0, t_do}; do_a[3] = {7'd0, c_do};
    sel_a[0] = f_sel; sel_a[1] = b_sel; sel_a[2] = t_sel; sel_a[3] = c_sel;
  end

  logic [7:0] mem [4][16384];
  logic [7:0] img [NPIX];
  int         ed [NPIX];
  int         et [NPIX];
  int         ee [NPIX];
  logic       load_req = 1'b0;
  int         proto_bad = 0;
  int         nvalid;
  int         total = 0;
  int         bad = 0;

  // RAM model and port protocol monitor: accesses registered at one posedge
  // take effect at the following negedge, which is equivalent to the RAM timing.
  always @(negedge clk) begin
    if (load_req) begin
      for (int a = 0; a < 16384; a++) begin
        mem[0][a] = 8'h00; mem[1][a] = 8'h5A; mem[2][a] = 8'hA5; mem[3][a] = 8'h3C;
      end
      for (int p = 0; p < NPIX; p++) mem[0][p] = img[p];
    end else begin
      nvalid = 0;
      for (int p = 0; p < 4; p++) begin
        if (sel_a[p] != 3'd7) nvalid++;
        if (rd_a[p] && wr_a[p]) proto_bad++;
        if ((rd_a[p] || wr_a[p]) && (sel_a[p] == 3'd1 || sel_a[p] > 3'd3)) proto_bad++;
        if ((rd_a[p] || wr_a[p]) && int'(addr_a[p]) >= NPIX) proto_bad++;
        if (wr_a[p] && sel_a[p] <= 3'd3) mem[sel_a[p][1:0]][addr_a[p]] = do_a[p];
        if (rd_a[p] && sel_a[p] <= 3'd3) di_a[p] = mem[sel_a[p][1:0]][addr_a[p]];
      end
      if (nvalid > 1) proto_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int dget(int r, int c);
    if (r < 0 || r >= W || c < 0 || c >= W) return 0;
    return ed[r*W + c];
  endfunction

  function automatic int tget(int r, int c);
    if (r < 0 || r >= W || c < 0 || c >= W) return 0;
    return et[r*W + c];
  endfunction

  function automatic int mn(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int inc_sat(int a);
    return (a >= 255) ? 255 : a + 1;
  endfunction

  // Reference: two-pass chessboard distance, threshold, 4-neighbour boundary.
  task automatic build_model();
    int m;
    for (int p = 0; p < NPIX; p++) ed[p] = int'(img[p]);
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++)
        if (ed[r*W + c] != 0) begin
          m = mn(mn(dget(r-1, c-1), dget(r-1, c)), mn(dget(r-1, c+1), dget(r, c-1)));
          ed[r*W + c] = inc_sat(m);
        end
    for (int r = W - 1; r >= 0; r--)
      for (int c = W - 1; c >= 0; c--)
        if (ed[r*W + c] != 0) begin
          m = mn(mn(dget(r, c+1), dget(r+1, c-1)), mn(dget(r+1, c), dget(r+1, c+1)));
          ed[r*W + c] = mn(ed[r*W + c], inc_sat(m));
        end
    for (int p = 0; p < NPIX; p++) et[p] = (ed[p] > THR) ? 1 : 0;
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++)
        ee[r*W + c] = (et[r*W + c] == 1 &&
                       (tget(r-1, c) == 0 || tget(r+1, c) == 0 ||
                        tget(r, c-1) == 0 || tget(r, c+1) == 0)) ? 1 : 0;
  endtask

  task automatic load_and_start();
    reset = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b1;
    @(negedge clk); #1;
    load_req = 1'b0;
    build_model();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic compare_all(input string tag);
    int m0, m1, m2, m3;
    m0 = 0; m1 = 0; m2 = 0; m3 = 0;
    for (int p = 0; p < NPIX; p++) begin
      if (mem[0][p] !== 8'(ed[p])) m0++;
      if (mem[3][p] !== 8'(et[p])) m3++;
      if (mem[2][p] !== 8'(ee[p])) m2++;
    end
    for (int a = 0; a < 16384; a++) if (mem[1][a] !== 8'h5A) m1++;
    chk({tag, "_ram0_diffs"}, m0, 0);
    chk({tag, "_ram3_diffs"}, m3, 0);
    chk({tag, "_ram2_diffs"}, m2, 0);
    chk({tag, "_ram1_touched"}, m1, 0);
    chk({tag, "_protocol"}, proto_bad, 0);
  endtask

  task automatic check_quiet(input string tag, input logic exp_done);
    chk({tag, "_strobes"}, {24'd0, f_rd, b_rd, t_rd, c_rd, f_wr, b_wr, t_wr, c_wr}, 32'd0);
    chk({tag, "_sels"}, {20'd0, f_sel, b_sel, t_sel, c_sel}, 32'hFFF);
    chk({tag, "_done_flag"}, {31'd0, done}, {31'd0, exp_done});
  endtask

  function automatic int sum_mem(int idx);
    int s;
    s = 0;
    for (int p = 0; p < NPIX; p++) s += int'(mem[idx][p]);
    return s;
  endfunction

  initial begin
    // reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset", 1'b0);
    chk("reset_addr", {18'd0, f_addr | b_addr | t_addr | c_addr}, 32'd0);
    chk("reset_do", {22'd0, f_do, b_do, t_do, c_do}, 32'd0);

    // all-zero image
    for (int p = 0; p < NPIX; p++) img[p] = 8'd0;
    load_and_start();
    wait_done("zero");
    compare_all("zero");
    chk("zero_ram3_sum", sum_mem(3), 0);
    chk("zero_ram2_sum", sum_mem(2), 0);

    // 5x5 block at rows/cols 10..14
    for (int p = 0; p < NPIX; p++)
      img[p] = (p / W >= 10 && p / W <= 14 && p % W >= 10 && p % W <= 14) ? 8'd1 : 8'd0;
    load_and_start();
    wait_done("block");
    compare_all("block");
    chk("block_d_centre", mem[0][12*W + 12], 3);
    chk("block_d_ring2", mem[0][11*W + 13], 2);
    chk("block_d_ring1", mem[0][14*W + 10], 1);
    chk("block_t_inner", mem[3][11*W + 11], 1);
    chk("block_t_outer", mem[3][10*W + 12], 0);
    chk("block_t_sum", sum_mem(3), 9);
    chk("block_e_centre", mem[2][12*W + 12], 0);
    chk("block_e_ring", mem[2][11*W + 12], 1);
    chk("block_e_sum", sum_mem(2), 8);

    // isolated pixel and one-pixel-wide line
    for (int p = 0; p < NPIX; p++)
      img[p] = (p == 3*W + 3 || (p / W == 8 && p % W >= 2 && p % W <= 13)) ? 8'd1 : 8'd0;
    load_and_start();
    wait_done("noise");
    compare_all("noise");
    chk("noise_d_pixel", mem[0][3*W + 3], 1);
    chk("noise_d_line", mem[0][8*W + 7], 1);
    chk("noise_ram3_sum", sum_mem(3), 0);
    chk("noise_ram2_sum", sum_mem(2), 0);

    // all-ones image
    for (int p = 0; p < NPIX; p++) img[p] = 8'd1;
    load_and_start();
    wait_done("ones");
    compare_all("ones");
    chk("ones_d_corner", mem[0][0], 1);
    chk("ones_d_centre", mem[0][(W/2 - 1)*W + (W/2 - 1)], W / 2);
    chk("ones_e_row1", mem[2][1*W + 5], 1);
    chk("ones_e_col14", mem[2][7*W + (W - 2)], 1);
    chk("ones_e_inner", mem[2][2*W + 5], 0);
    chk("ones_e_border", mem[2][0], 0);
    chk("ones_e_sum", sum_mem(2), 4 * (W - 3));

    // randomized images at two densities
    for (int run = 0; run < 2; run++) begin
      for (int p = 0; p < NPIX; p++)
        img[p] = ($urandom_range(0, 99) < (run == 0 ? 60 : 88)) ? 8'd1 : 8'd0;
      load_and_start();
      wait_done($sformatf("rand%0d", run));
      compare_all($sformatf("rand%0d", run));
    end

    // reset pulse during the forward pass, then a clean restart
    for (int p = 0; p < NPIX; p++)
      img[p] = ($urandom_range(0, 99) < 75) ? 8'd1 : 8'd0;
    load_and_start();
    repeat (200) @(posedge clk);
    #1;
    chk("midfwd_sel", {29'd0, f_sel}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_quiet("midfwd_reset", 1'b0);
    reset = 1'b0;
    wait_done("restart");
    compare_all("restart");

    // done is held with the ports quiet
    repeat (5) @(posedge clk);
    #1;
    check_quiet("hold", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
